// File: rtl/id_ctrl_redirect.sv
// ID-stage control for the pipelined MIPS core: the IF/ID register, control-transfer
// resolution feeding fetch redirects, hazard stall detection, and saturating
// stall/flush counters.
module id_ctrl_redirect #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      Instruction_if,
   input  logic [31:0]      NextPC_if,
   input  logic [31:0]      RsData_id,
   input  logic [31:0]      RtData_id,
   input  logic             RegWrite_ex,
   input  logic             MemRead_ex,
   input  logic [4:0]       WriteReg_ex,
   input  logic             MemRead_mem,
   input  logic [4:0]       WriteReg_mem,
   output logic [31:0]      Instruction_id,
   output logic [31:0]      NextPC_id,
   output logic [4:0]       RsAddr_id,
   output logic [4:0]       RtAddr_id,
   output logic             Z,
   output logic             J,
   output logic             JR,
   output logic             PC_IFWrite,
   output logic             Stall_id,
   output logic [31:0]      JumpAddr,
   output logic [31:0]      JrAddr,
   output logic [31:0]      BranchAddr,
   output logic [CNT_W-1:0] StallCount,
   output logic [CNT_W-1:0] FlushCount
);

   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_J     = 6'd2;
   localparam logic [5:0] OP_JAL   = 6'd3;
   localparam logic [5:0] OP_BEQ   = 6'd4;
   localparam logic [5:0] OP_BNE   = 6'd5;
   localparam logic [5:0] OP_SW    = 6'd43;
   localparam logic [5:0] FN_JR    = 6'd8;

   logic [31:0]      instr_q, instr_d;
   logic [31:0]      npc_q, npc_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic [5:0] op, funct;
   logic [4:0] rs, rt;
   logic       is_beq, is_bne, is_j, is_jal, is_jr, is_rtype, is_sw;
   logic       uses_rs, uses_rt, is_ctrl;
   logic       match_ex, match_mem;
   logic       hazard, redirect;
   logic       z_raw, j_raw, jr_raw;

   // Field extraction and opcode decode of the instruction held in ID.
   always_comb begin
      op       = instr_q[31:26];
      funct    = instr_q[5:0];
      rs       = instr_q[25:21];
      rt       = instr_q[20:16];
      is_beq   = (op == OP_BEQ);
      is_bne   = (op == OP_BNE);
      is_j     = (op == OP_J);
      is_jal   = (op == OP_JAL);
      is_jr    = (op == OP_RTYPE) && (funct == FN_JR);
      is_rtype = (op == OP_RTYPE) && (funct != FN_JR);
      is_sw    = (op == OP_SW);
      uses_rs  = !(is_j || is_jal);
      uses_rt  = is_rtype || is_beq || is_bne || is_sw;
      is_ctrl  = is_beq || is_bne || is_jr;
   end

   // Hazard detection: a producer in EX/MEM whose destination is a live source here.
   // Register 0 is hard-wired, so it never creates a dependency.
   always_comb begin
      match_ex  = (WriteReg_ex != 5'd0) &&
                  (((WriteReg_ex == rs) && uses_rs) || ((WriteReg_ex == rt) && uses_rt));
      match_mem = (WriteReg_mem != 5'd0) &&
                  (((WriteReg_mem == rs) && uses_rs) || ((WriteReg_mem == rt) && uses_rt));
      hazard    = (MemRead_ex && match_ex) ||
                  (is_ctrl && RegWrite_ex && match_ex) ||
                  (is_ctrl && MemRead_mem && match_mem);
   end

   // Redirect resolution; suppressed while stalled so it is taken once operands are valid.
   always_comb begin
      z_raw    = (is_beq && (RsData_id == RtData_id)) || (is_bne && (RsData_id != RtData_id));
      j_raw    = is_j || is_jal;
      jr_raw   = is_jr;
      redirect = !hazard && (z_raw || j_raw || jr_raw);
   end

   // Next-state for the IF/ID register (stall beats flush beats load) and the counters.
   always_comb begin
      instr_d     = Instruction_if;
      npc_d       = NextPC_if;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (hazard) begin
         instr_d = instr_q;
         npc_d   = npc_q;
         if (stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
         end
      end else if (redirect) begin
         instr_d = 32'd0;
         npc_d   = 32'd0;
         if (flush_cnt_q != '1) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
         end
      end
   end

   // IF/ID pipeline register and performance counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         instr_q     <= 32'd0;
         npc_q       <= 32'd0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         instr_q     <= instr_d;
         npc_q       <= npc_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign Instruction_id = instr_q;
   assign NextPC_id      = npc_q;
   assign RsAddr_id      = rs;
   assign RtAddr_id      = rt;
   assign Z              = z_raw && !hazard;
   assign J              = j_raw && !hazard;
   assign JR             = jr_raw && !hazard;
   assign PC_IFWrite     = !hazard;
   assign Stall_id       = hazard;
   assign BranchAddr     = npc_q + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
   assign JumpAddr       = {npc_q[31:28], instr_q[25:0], 2'b00};
   assign JrAddr         = RsData_id;
   assign StallCount     = stall_cnt_q;
   assign FlushCount     = flush_cnt_q;

endmodule

// File: tb/tb_id_ctrl_redirect.sv
// Bench for id_ctrl_redirect: directed vectors, an instruction-level reference model
// checked on every falling edge, and literal expectations for each scenario.
module tb_id_ctrl_redirect;

   localparam int CNT_W = 16;
   localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

   logic             clk;
   logic             reset;
   logic [31:0]      Instruction_if, NextPC_if, RsData_id, RtData_id;
   logic             RegWrite_ex, MemRead_ex, MemRead_mem;
   logic [4:0]       WriteReg_ex, WriteReg_mem;
   logic [31:0]      Instruction_id, NextPC_id;
   logic [4:0]       RsAddr_id, RtAddr_id;
   logic             Z, J, JR, PC_IFWrite, Stall_id;
   logic [31:0]      JumpAddr, JrAddr, BranchAddr;
   logic [CNT_W-1:0] StallCount, FlushCount;

   int checks = 0;
   int errors = 0;

   id_ctrl_redirect #(.CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .Instruction_if(Instruction_if), .NextPC_if(NextPC_if),
      .RsData_id(RsData_id), .RtData_id(RtData_id),
      .RegWrite_ex(RegWrite_ex), .MemRead_ex(MemRead_ex), .WriteReg_ex(WriteReg_ex),
      .MemRead_mem(MemRead_mem), .WriteReg_mem(WriteReg_mem),
      .Instruction_id(Instruction_id), .NextPC_id(NextPC_id),
      .RsAddr_id(RsAddr_id), .RtAddr_id(RtAddr_id),
      .Z(Z), .J(J), .JR(JR), .PC_IFWrite(PC_IFWrite), .Stall_id(Stall_id),
      .JumpAddr(JumpAddr), .JrAddr(JrAddr), .BranchAddr(BranchAddr),
      .StallCount(StallCount), .FlushCount(FlushCount)
   );

   // Clock and watchdog.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit expired");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic        hazard;
      logic        z, j, jr;
      logic [31:0] branch, jump;
   } exp_t;

   function automatic exp_t predict(input logic [31:0] instr, input logic [31:0] npc,
                                    input logic [31:0] rsd, input logic [31:0] rtd,
                                    input logic rw_ex, input logic mr_ex, input logic [4:0] wr_ex,
                                    input logic mr_mem, input logic [4:0] wr_mem);
      exp_t  e;
      string kind;
      int    srcs[$];
      int    op, fn;
      bit    ctrl;
      op = int'(instr[31:26]);
      fn = int'(instr[5:0]);
      case (op)
         0:       kind = (fn == 8) ? "jr" : "rtype";
         2:       kind = "j";
         3:       kind = "jal";
         4:       kind = "beq";
         5:       kind = "bne";
         43:      kind = "sw";
         default: kind = "other";
      endcase
      if (kind != "j" && kind != "jal") srcs.push_back(int'(instr[25:21]));
      if (kind == "rtype" || kind == "beq" || kind == "bne" || kind == "sw")
         srcs.push_back(int'(instr[20:16]));
      ctrl = (kind == "beq" || kind == "bne" || kind == "jr");
      e.hazard = 1'b0;
      foreach (srcs[i]) begin
         if (srcs[i] != 0) begin
            if (mr_ex && srcs[i] == int'(wr_ex)) e.hazard = 1'b1;
            if (ctrl && rw_ex && srcs[i] == int'(wr_ex)) e.hazard = 1'b1;
            if (ctrl && mr_mem && srcs[i] == int'(wr_mem)) e.hazard = 1'b1;
         end
      end
      e.z  = !e.hazard && ((kind == "beq" && rsd == rtd) || (kind == "bne" && rsd != rtd));
      e.j  = !e.hazard && (kind == "j" || kind == "jal");
      e.jr = !e.hazard && (kind == "jr");
      e.branch = npc + 32'(int'($signed(instr[15:0])) * 4);
      e.jump   = (npc & 32'hF000_0000) + (32'(instr[25:0]) * 4);
      return e;
   endfunction

   logic [31:0] m_instr, m_npc;
   int unsigned m_stall, m_flush;
   exp_t        cur;

   always_comb cur = predict(m_instr, m_npc, RsData_id, RtData_id, RegWrite_ex, MemRead_ex,
                             WriteReg_ex, MemRead_mem, WriteReg_mem);

   // Model state advances on the same edges as the design.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_instr <= 32'd0;
         m_npc   <= 32'd0;
         m_stall <= 0;
         m_flush <= 0;
      end else if (cur.hazard) begin
         if (m_stall < CNT_MAX) m_stall <= m_stall + 1;
      end else if (cur.z || cur.j || cur.jr) begin
         m_instr <= 32'd0;
         m_npc   <= 32'd0;
         if (m_flush < CNT_MAX) m_flush <= m_flush + 1;
      end else begin
         m_instr <= Instruction_if;
         m_npc   <= NextPC_if;
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      chk("m_instr_id", Instruction_id, m_instr);
      chk("m_npc_id",   NextPC_id, m_npc);
      chk("m_rs_addr",  32'(RsAddr_id), 32'(m_instr[25:21]));
      chk("m_rt_addr",  32'(RtAddr_id), 32'(m_instr[20:16]));
      chk("m_z",        32'(Z), 32'(cur.z));
      chk("m_j",        32'(J), 32'(cur.j));
      chk("m_jr",       32'(JR), 32'(cur.jr));
      chk("m_pcwrite",  32'(PC_IFWrite), 32'(!cur.hazard));
      chk("m_stall_id", 32'(Stall_id), 32'(cur.hazard));
      chk("m_jump",     JumpAddr, cur.jump);
      chk("m_jraddr",   JrAddr, RsData_id);
      chk("m_branch",   BranchAddr, cur.branch);
      chk("m_stallcnt", 32'(StallCount), m_stall);
      chk("m_flushcnt", 32'(FlushCount), m_flush);
      chk("m_onehot",   32'($countones({Z, J, JR}) <= 1), 32'd1);
   end

   // ---------------- driver ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      Instruction_if = 32'd0; NextPC_if = 32'd0;
      RsData_id = 32'd0; RtData_id = 32'd0;
      RegWrite_ex = 1'b0; MemRead_ex = 1'b0; WriteReg_ex = 5'd0;
      MemRead_mem = 1'b0; WriteReg_mem = 5'd0;
      reset = 1'b0;
      #1 reset = 1'b1;
      tick(); tick();
      reset = 1'b0;

      // Beq taken then not taken.
      Instruction_if = 32'h1022_0003; NextPC_if = 32'h10;
      tick();
      RsData_id = 32'd5; RtData_id = 32'd5;
      Instruction_if = 32'h00A5_3020; NextPC_if = 32'h14;
      settle();
      chk("beq_loaded", Instruction_id, 32'h1022_0003);
      chk("beq_z", 32'(Z), 32'd1);
      chk("beq_target", BranchAddr, 32'h1C);
      tick();
      chk("beq_flush", Instruction_id, 32'd0);
      chk("beq_flushcnt", 32'(FlushCount), 32'd1);
      Instruction_if = 32'h1022_0003; NextPC_if = 32'h10;
      tick();
      RtData_id = 32'd6;
      Instruction_if = 32'h0022_1820; NextPC_if = 32'h14;
      settle();
      chk("beq_nt_z", 32'(Z), 32'd0);
      tick();
      chk("beq_nt_next", Instruction_id, 32'h0022_1820);
      chk("beq_nt_npc", NextPC_id, 32'h14);

      // Asynchronous reset mid-cycle.
      #2 reset = 1'b1;
      settle();
      chk("rst_instr", Instruction_id, 32'd0);
      chk("rst_flushcnt", 32'(FlushCount), 32'd0);
      chk("rst_pcwrite", 32'(PC_IFWrite), 32'd1);
      chk("rst_zjjr", 32'({Z, J, JR}), 32'd0);
      tick();
      reset = 1'b0;

      // Jump and register jump, each followed by a bubble.
      Instruction_if = 32'h0800_000B; NextPC_if = 32'h20;
      tick();
      Instruction_if = 32'h00A5_3020; NextPC_if = 32'h24;
      settle();
      chk("j_j", 32'(J), 32'd1);
      chk("j_target", JumpAddr, 32'd44);
      tick();
      chk("j_bubble", Instruction_id, 32'd0);
      chk("j_flushcnt", 32'(FlushCount), 32'd1);
      Instruction_if = 32'h03E0_0008; NextPC_if = 32'h28;
      RsData_id = 32'd52;
      tick();
      Instruction_if = 32'h00A5_3020; NextPC_if = 32'h2C;
      settle();
      chk("jr_jr", 32'(JR), 32'd1);
      chk("jr_target", JrAddr, 32'd52);
      tick();
      chk("jr_bubble", Instruction_id, 32'd0);
      chk("jr_flushcnt", 32'(FlushCount), 32'd2);

      // Load-use stall.
      Instruction_if = 32'h0022_1820; NextPC_if = 32'h30;
      tick();
      MemRead_ex = 1'b1; WriteReg_ex = 5'd2;
      Instruction_if = 32'h0064_1020; NextPC_if = 32'h34;
      settle();
      chk("lu_pcwrite", 32'(PC_IFWrite), 32'd0);
      chk("lu_stall", 32'(Stall_id), 32'd1);
      tick();
      chk("lu_held", Instruction_id, 32'h0022_1820);
      chk("lu_stallcnt", 32'(StallCount), 32'd1);
      MemRead_ex = 1'b0;
      settle();
      chk("lu_release", 32'(PC_IFWrite), 32'd1);
      tick();
      chk("lu_next", Instruction_id, 32'h0064_1020);
      chk("lu_stallcnt2", 32'(StallCount), 32'd1);

      // Branch waiting on an EX result.
      Instruction_if = 32'h1022_0003; NextPC_if = 32'h40;
      RsData_id = 32'd7; RtData_id = 32'd7;
      tick();
      RegWrite_ex = 1'b1; WriteReg_ex = 5'd1;
      Instruction_if = 32'd0; NextPC_if = 32'h44;
      settle();
      chk("bex_z_stalled", 32'(Z), 32'd0);
      chk("bex_stall", 32'(Stall_id), 32'd1);
      tick();
      RegWrite_ex = 1'b0;
      settle();
      chk("bex_z", 32'(Z), 32'd1);
      chk("bex_target", BranchAddr, 32'h4C);
      tick();
      chk("bex_flush", Instruction_id, 32'd0);
      chk("bex_counts", {16'(StallCount), 16'(FlushCount)}, {16'd2, 16'd3});

      // Branch waiting on a load in MEM.
      Instruction_if = 32'h1022_0003; NextPC_if = 32'h40;
      tick();
      MemRead_mem = 1'b1; WriteReg_mem = 5'd2;
      Instruction_if = 32'd0;
      settle();
      chk("bmem_z_stalled", 32'(Z), 32'd0);
      chk("bmem_pcwrite", 32'(PC_IFWrite), 32'd0);
      tick();
      MemRead_mem = 1'b0;
      settle();
      chk("bmem_z", 32'(Z), 32'd1);
      tick();
      chk("bmem_counts", {16'(StallCount), 16'(FlushCount)}, {16'd3, 16'd4});

      // Register 0 never creates a dependency.
      Instruction_if = 32'h1022_0003; NextPC_if = 32'h40;
      tick();
      RegWrite_ex = 1'b1; WriteReg_ex = 5'd0;
      settle();
      chk("r0_pcwrite", 32'(PC_IFWrite), 32'd1);
      chk("r0_z", 32'(Z), 32'd1);
      tick();
      RegWrite_ex = 1'b0;
      chk("r0_flushcnt", 32'(FlushCount), 32'd5);

      // Saturation under a long stall, then reset during the stall.
      Instruction_if = 32'h0022_1820; NextPC_if = 32'h50;
      tick();
      MemRead_ex = 1'b1; WriteReg_ex = 5'd1;
      Instruction_if = 32'h0064_1020; NextPC_if = 32'h54;
      repeat ((1 << CNT_W) + 3) tick();
      chk("sat_stallcnt", 32'(StallCount), 32'(CNT_MAX));
      chk("sat_held", Instruction_id, 32'h0022_1820);
      #2 reset = 1'b1;
      settle();
      chk("sat_rst_cnt", 32'(StallCount), 32'd0);
      MemRead_ex = 1'b0; WriteReg_ex = 5'd0;
      settle();
      chk("sat_rst_pcwrite", 32'(PC_IFWrite), 32'd1);
      tick();
      reset = 1'b0;
      tick(); tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
